kianv_mem_responder: RTL
========================

KIANV_MEM_RESPONDER -- requirements
Module: kianv_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words of internal storage.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0; word-aligned.
REQ-003 SHALL have parameter WAIT_STATES, default 2: extra latency cycles, legal range 0..15.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk, input, 1: sole clock, all state updates on rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous active-high reset.
REQ-007 SHALL have port mem_valid, input, 1: initiator request.
REQ-008 SHALL have port mem_ready, output, 1: one-cycle completion pulse.
REQ-009 SHALL have port mem_wstrb, input, 4: byte-lane write enables; 4'b0000 means read.
REQ-010 SHALL have port mem_addr, input, 32: byte address.
REQ-011 SHALL have port mem_wdata, input, 32: write data.
REQ-012 SHALL have port mem_rdata, output, 32: read data, valid only while mem_ready=1.
REQ-013 SHALL have port access_fault, output, 1: unmapped-address flag, valid only while mem_ready=1.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, ACK; all outputs registered.
REQ-015 In IDLE with mem_valid=1, the block SHALL latch mem_addr, mem_wstrb and mem_wdata, load the wait counter with WAIT_STATES, and go to WAIT, or to ACK if WAIT_STATES=0.
REQ-016 In WAIT the block SHALL decrement the counter each cycle and go to ACK on the cycle it reaches 0.
REQ-017 mem_ready SHALL be high for exactly the one ACK cycle, WAIT_STATES+1 cycles after the accepting edge; after ACK the FSM SHALL return to IDLE.
REQ-018 A request SHALL be accepted only in IDLE; mem_valid high during ACK does not start a new transaction until the following IDLE cycle.
REQ-019 Latched request fields SHALL be used for the whole transaction; input changes in WAIT/ACK are ignored.
REQ-020 If mem_valid drops during WAIT, the transaction SHALL still complete and ACK is still issued.
REQ-021 Address is in range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS (32-bit unsigned compare); word index = (addr - BASE_ADDR) >> 2; addr[1:0] ignored.
REQ-022 In-range read (wstrb=0): mem_rdata SHALL equal the stored word in ACK; access_fault=0.
REQ-023 In-range write: each byte lane i with wstrb[i]=1 SHALL take wdata[8i+7:8i], committed at the ACK-ending edge; other lanes unchanged; mem_rdata=0 in ACK.
REQ-024 Out-of-range access: no storage change; mem_rdata=0 and access_fault=1 in ACK.
REQ-025 Outside ACK, mem_ready=0, access_fault=0, mem_rdata=0.
REQ-026 A read following a write to the same word SHALL return the written data.

Reset
REQ-027 On reset: FSM=IDLE, counter=0, mem_ready=0, access_fault=0, mem_rdata=0; storage contents unchanged.
REQ-028 Reset during WAIT or ACK SHALL abort the transaction: no write is committed and no mem_ready pulse follows.

Verification
REQ-029 Read latency: WAIT_STATES=2; read 0x0000_0010 holding 0xDEADBEEF -> mem_ready exactly 3 cycles after acceptance, mem_rdata=0xDEADBEEF, access_fault=0.
REQ-030 Byte write: word 0x8 = 0x11223344; write wstrb=4'b0101, wdata=0xAABBCCDD -> subsequent read returns 0x11BB33DD.
REQ-031 Fault: DEPTH_WORDS=1024, BASE=0; write to 0x0000_1000 -> mem_ready with access_fault=1, mem_rdata=0; word 0 unchanged.
REQ-032 Zero wait: WAIT_STATES=0, back-to-back reads with mem_valid held high -> one mem_ready per transaction, each 1 cycle after acceptance, one IDLE cycle between.
REQ-033 Reset abort: write 0xCAFEF00D to 0x4 with reset asserted in WAIT -> no mem_ready; subsequent read of 0x4 returns the prior value.
REQ-034 Input hold: change mem_addr and mem_wdata during WAIT -> transaction uses originally latched values.

Source files
------------

// File: rtl/kianv_mem_responder.sv
// Word-organised memory slave for a valid/ready bus with a fixed, parameterised latency.
// Out-of-range addresses finish the handshake normally and raise access_fault.
module kianv_mem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        access_fault
);

  localparam int          IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] req_addr;
  logic [3:0]  req_wstrb;
  logic        req_hit;
  logic [31:0] mem [DEPTH_WORDS];

  // 33-bit subtraction: a borrow into bit 32 means the address lies below BASE_ADDR.
  function automatic logic in_range(input logic [31:0] addr);
    logic [32:0] off;
    off = {1'b0, addr} - {1'b0, BASE_ADDR};
    return !off[32] && (off < LIMIT);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> 2);
  endfunction

  // With zero wait states the ACK outputs are formed on the accepting edge,
  // before the request fields have been latched, so use the live inputs then.
  assign req_addr  = (state == IDLE) ? mem_addr  : addr_q;
  assign req_wstrb = (state == IDLE) ? mem_wstrb : wstrb_q;
  assign req_hit   = in_range(req_addr);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (mem_valid) begin
          cnt_nxt   = 4'(WAIT_STATES);
          state_nxt = (WAIT_STATES == 0) ? ACK : WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) state_nxt = ACK;
      end
      ACK: begin
        cnt_nxt   = 4'd0;
        state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = 4'd0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      mem_ready    <= 1'b0;
      access_fault <= 1'b0;
      mem_rdata    <= 32'd0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      mem_ready    <= (state_nxt == ACK);
      access_fault <= (state_nxt == ACK) && !req_hit;
      mem_rdata    <= ((state_nxt == ACK) && req_hit && (req_wstrb == 4'd0))
                      ? mem[word_idx(req_addr)] : 32'd0;
    end
  end

  // Request capture and storage are never reset; a reset on the ACK-ending edge
  // suppresses the commit so an aborted write leaves memory untouched.
  always_ff @(posedge clk) begin
    if (state == IDLE && mem_valid) begin
      addr_q  <= mem_addr;
      wstrb_q <= mem_wstrb;
      wdata_q <= mem_wdata;
    end
    if (!reset && state == ACK && wstrb_q != 4'd0 && in_range(addr_q)) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem[word_idx(addr_q)][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule
